// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
//   The WIDTH/GROUP lookahead groups are divided into STAGES contiguous
//   slices (LSB slice first). Each slice computes group propagate/generate,
//   runs the group carry chain and finishes its sum bits. It then registers
//   the carry leaving the slice, the finished low sum bits and the operands
//   that later slices still need.
//
// Handshake (valid/ready):
//   A beat moves across an interface on a rising edge where valid && ready.
//   Stage k advances when it is empty or stage k+1 advances. The last stage
//   advances when it is empty or out_ready is high. in_ready is the advance
//   of stage 0. It depends combinationally on out_ready only, never on
//   in_valid. Outputs are last-stage registers and hold while
//   out_valid && !out_ready.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand beat handshake
//   a, b, cin, sub     operands; sub inverts b, cin is used as-is
//   out_valid/out_ready result beat handshake
//   sum, cout          {cout, sum} = a + (b ^ {WIDTH{sub}}) + cin
//   ovf, zero          signed overflow, sum == 0
//   stage_valid        per-stage occupancy (debug)
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  sum,
    output logic              cout,
    output logic              ovf,
    output logic              zero,
    output logic [STAGES-1:0] stage_valid
);

    localparam int NG = WIDTH / GROUP;
    localparam int L  = STAGES - 1;

    // First group index owned by slice k (floor split; slice k ends where k+1 starts).
    function automatic int slice_lo(input int k);
        return (k * NG) / STAGES;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bp_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic              ovf_q, zero_q;

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] nxt_c;
    logic [WIDTH-1:0]  src_a  [STAGES];
    logic [WIDTH-1:0]  src_bp [STAGES];
    logic [WIDTH-1:0]  src_s  [STAGES];
    logic [WIDTH-1:0]  nxt_s  [STAGES];
    logic [WIDTH-1:0]  bp_in;
    logic              ovf_d, zero_d;

    assign bp_in = b ^ {WIDTH{sub}};

    // What each stage would capture: the input port for stage 0, else the previous stage.
    always_comb begin
        src_v[0]  = in_valid;
        src_a[0]  = a;
        src_bp[0] = bp_in;
        src_s[0]  = '0;
        src_c[0]  = cin;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]  = v_q[k-1];
            src_a[k]  = a_q[k-1];
            src_bp[k] = bp_q[k-1];
            src_s[k]  = s_q[k-1];
            src_c[k]  = c_q[k-1];
        end
    end

    // Ready chain, walked from the output back to the input.
    always_comb begin
        logic r;
        r   = out_ready;
        adv = '0;
        for (int k = L; k >= 0; k--) begin
            r      = !v_q[k] || r;
            adv[k] = r;
        end
    end

    // Slice arithmetic. Group generate is built LSB-up as gg = g_j | p_j & gg,
    // the group carry then skips the whole group with cout = GG | GP & cin.
    always_comb begin
        logic c, ci, gp, gg, p, gn;
        int   bi;
        c  = 1'b0;
        ci = 1'b0;
        gp = 1'b0;
        gg = 1'b0;
        p  = 1'b0;
        gn = 1'b0;
        bi = 0;
        for (int k = 0; k < STAGES; k++) begin
            nxt_s[k] = src_s[k];
            c        = src_c[k];
            for (int g = 0; g < NG; g++) begin
                if (g >= slice_lo(k) && g < slice_lo(k + 1)) begin
                    gp = 1'b1;
                    gg = 1'b0;
                    ci = c;
                    for (int j = 0; j < GROUP; j++) begin
                        bi           = g * GROUP + j;
                        p            = src_a[k][bi] ^ src_bp[k][bi];
                        gn           = src_a[k][bi] & src_bp[k][bi];
                        nxt_s[k][bi] = p ^ ci;
                        ci           = gn | (p & ci);
                        gg           = gn | (p & gg);
                        gp           = gp & p;
                    end
                    c = gg | (gp & c);
                end
            end
            nxt_c[k] = c;
        end
    end

    // Flags are formed as the last slice finishes so they register with the sum.
    assign ovf_d  = (src_a[L][WIDTH-1] == src_bp[L][WIDTH-1]) &&
                    (nxt_s[L][WIDTH-1] != src_a[L][WIDTH-1]);
    assign zero_d = (nxt_s[L] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bp_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= src_v[k];
                end
                // Data only loads with a real beat, so an empty stage keeps its old value.
                if (adv[k] && src_v[k]) begin
                    a_q[k]  <= src_a[k];
                    bp_q[k] <= src_bp[k];
                    s_q[k]  <= nxt_s[k];
                    c_q[k]  <= nxt_c[k];
                end
            end
            if (adv[L] && src_v[L]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign in_ready    = adv[0];
    assign out_valid   = v_q[L];
    assign sum         = s_q[L];
    assign cout        = c_q[L];
    assign ovf         = ovf_q;
    assign zero        = zero_q;
    assign stage_valid = v_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: a 32/4/2 main instance plus 32/4/1 and 16/8/2
// instances that share the input stimulus.
module tb_cla_pipe_addsub;

  localparam int EW = 51;  // {accept cycle[15:0], sum[31:0], cout, ovf, zero}
  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, cin, sub, out_ready;
  logic [31:0] a, b;

  logic        m_in_ready, m_out_valid, m_cout, m_ovf, m_zero;
  logic [31:0] m_sum;
  logic [1:0]  m_stv;
  logic        s_in_ready, s_out_valid, s_cout, s_ovf, s_zero;
  logic [31:0] s_sum;
  logic [0:0]  s_stv;
  logic        w_in_ready, w_out_valid, w_cout, w_ovf, w_zero;
  logic [15:0] w_sum;
  logic [1:0]  w_stv;

  logic        m_rdy, m_vld, s_rdy, s_vld, w_rdy, w_vld;
  logic [34:0] m_res, s_res, w_res;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] s1_q[$];
  logic [EW-1:0] w_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(2)) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(m_out_valid), .out_ready(out_ready),
    .sum(m_sum), .cout(m_cout), .ovf(m_ovf), .zero(m_zero), .stage_valid(m_stv)
  );

  cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .sum(s_sum), .cout(s_cout), .ovf(s_ovf), .zero(s_zero), .stage_valid(s_stv)
  );

  cla_pipe_addsub #(.WIDTH(16), .GROUP(8), .STAGES(2)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .sum(w_sum), .cout(w_cout), .ovf(w_ovf), .zero(w_zero), .stage_valid(w_stv)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Integer arithmetic on the true values; overflow is a range check on the
  // exact signed sum.
  function automatic logic [34:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb, input int w);
    longint unsigned mask, ua, ub, t;
    longint          sa, sbv, st, half;
    logic [31:0]     s;
    logic            co, ov, z;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & mask;
    ub   = (sb ? ~longint'(bv) : longint'(bv)) & mask;
    t    = ua + ub + longint'(ci);
    s    = 32'(t & mask);
    co   = ((t >> w) & 1) != 0;
    sa   = (ua >= half) ? longint'(ua) - 2 * half : longint'(ua);
    sbv  = (ub >= half) ? longint'(ub) - 2 * half : longint'(ub);
    st   = sa + sbv + longint'(ci);
    ov   = (st > half - 1) || (st < -half);
    z    = (s == 32'd0);
    return {s, co, ov, z};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1: applies inputs, snapshots every DUT at the falling
  // edge, then returns at the next posedge+1.
  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb, input logic ordy);
    in_valid  = v;
    a         = av;
    b         = bv;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    @(negedge clk);
    m_rdy = m_in_ready; m_vld = m_out_valid; m_res = {m_sum, m_cout, m_ovf, m_zero};
    s_rdy = s_in_ready; s_vld = s_out_valid; s_res = {s_sum, s_cout, s_ovf, s_zero};
    w_rdy = w_in_ready; w_vld = w_out_valid; w_res = {16'h0, w_sum, w_cout, w_ovf, w_zero};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({m_out_valid, m_sum, m_cout, m_ovf, m_zero} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_main: got %h expected 0", {m_out_valid, m_sum, m_cout, m_ovf, m_zero});
    end
    n_vec++;
    if ({s_out_valid, s_sum, w_out_valid, w_sum} !== 50'h0) begin
      n_err++;
      $display("FAIL reset_variants: got %h expected 0", {s_out_valid, s_sum, w_out_valid, w_sum});
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({m_in_ready, s_in_ready, w_in_ready, m_out_valid} !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_ready: got %b expected 1110", {m_in_ready, s_in_ready, w_in_ready, m_out_valid});
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005};
    logic [31:0] tb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007};
    logic        tc [3] = '{1'b0, 1'b0, 1'b1};
    logic        ts [3] = '{1'b0, 1'b0, 1'b1};
    logic [34:0] te [3] = '{{32'h0000_0000, 3'b101}, {32'h8000_0000, 3'b010},
                            {32'hFFFF_FFFE, 3'b000}};
    for (int i = 0; i < 3; i++) begin
      int   lat;
      logic found;
      logic [34:0] got;
      drive(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1);
      n_vec++;
      if (m_rdy !== 1'b1) begin
        n_err++;
        $display("FAIL directed_accept[%0d]: got in_ready=%b expected 1", i, m_rdy);
      end
      found = 1'b0; lat = 0; got = '0;
      for (int c = 1; c <= 8 && !found; c++) begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        if (m_vld) begin found = 1'b1; lat = c; got = m_res; end
      end
      n_vec++;
      if (!found || lat != MS) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, MS);
      end
      n_vec++;
      if (got !== te[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got %h expected %h", i, got, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got_n = 0;
    exp_q.delete();
    for (int c = 0; c < 110; c++) begin
      logic [31:0] av, bv;
      logic        ci, sb;
      int          cur;
      cur = cyc;
      av = rnd32(); bv = rnd32();
      ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      if (c < 100) drive(1'b1, av, bv, ci, sb, 1'b1);
      else         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      if (c >= MS && c < 100 + MS) begin
        n_vec++;
        if (m_vld !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_throughput[%0d]: got out_valid=%b expected 1", c, m_vld);
        end
      end
      if (m_vld) begin
        logic [EW-1:0] e;
        logic [15:0]   lat;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_spurious[%0d]: got %h expected no beat", c, m_res);
        end else begin
          e = exp_q.pop_front();
          lat = 16'(cur) - e[50:35];
          got_n++;
          if (m_res !== e[34:0] || lat != 16'(MS)) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: got %h lat %0d expected %h lat %0d",
                     c, m_res, lat, e[34:0], MS);
          end
        end
      end
      if (c < 100) begin
        n_vec++;
        if (m_rdy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready[%0d]: got %b expected 1", c, m_rdy);
        end else begin
          exp_q.push_back({16'(cur), model(av, bv, ci, sb, 32)});
        end
      end
    end
    n_vec++;
    if (got_n != 100 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results expected 100", got_n);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ba [6];
    logic [31:0] bb [6];
    logic        bc [6];
    logic        bs [6];
    int          idx = 0, got_n = 0;
    logic        prev_stall = 1'b0;
    logic [34:0] prev_res = '0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      ba[i] = rnd32(); bb[i] = rnd32();
      bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 40 && got_n < 6; c++) begin
      logic ordy, sent, exp_rdy;
      int   cur;
      cur  = cyc;
      ordy = !(c >= 3 && c <= 8);
      sent = (idx < 6);
      if (sent) drive(1'b1, ba[idx], bb[idx], bc[idx], bs[idx], ordy);
      else      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ordy);
      // Input is only refused when every stage is full and the sink stalls.
      exp_rdy = ordy || (exp_q.size() < MS);
      n_vec++;
      if (m_rdy !== exp_rdy) begin
        n_err++;
        $display("FAIL bp_ready[%0d]: got %b expected %b", c, m_rdy, exp_rdy);
      end
      if (prev_stall) begin
        n_vec++;
        if (m_vld !== 1'b1 || m_res !== prev_res) begin
          n_err++;
          $display("FAIL bp_stable[%0d]: got %b/%h expected 1/%h", c, m_vld, m_res, prev_res);
        end
      end
      prev_stall = m_vld && !ordy;
      prev_res   = m_res;
      if (m_vld && ordy) begin
        logic [EW-1:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_spurious[%0d]: got %h expected no beat", c, m_res);
        end else begin
          e = exp_q.pop_front();
          got_n++;
          if (m_res !== e[34:0]) begin
            n_err++;
            $display("FAIL bp_result[%0d]: got %h expected %h", c, m_res, e[34:0]);
          end
        end
      end
      if (sent && m_rdy) begin
        exp_q.push_back({16'(cur), model(ba[idx], bb[idx], bc[idx], bs[idx], 32)});
        idx++;
      end
    end
    n_vec++;
    if (got_n != 6 || idx != 6 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: got %0d/%0d expected 6/6", idx, got_n);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] av, bv;
    logic [34:0] e;
    int          seen = 0, lat = 0, start;
    logic [34:0] got = '0;
    drive(1'b1, rnd32(), rnd32(), 1'b0, 1'b0, 1'b1);
    drive(1'b1, rnd32(), rnd32(), 1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({m_out_valid, m_sum, m_cout, m_ovf, m_zero} !== 36'h0) begin
      n_err++;
      $display("FAIL midreset_clear: got %h expected 0", {m_out_valid, m_sum, m_cout, m_ovf, m_zero});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    av = rnd32(); bv = rnd32();
    e = model(av, bv, 1'b1, 1'b0, 32);
    start = cyc;
    drive(1'b1, av, bv, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (m_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_accept: got %b expected 1", m_rdy);
    end
    for (int c = 0; c < 6; c++) begin
      int cur;
      cur = cyc;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      if (m_vld) begin seen++; lat = cur - start; got = m_res; end
    end
    n_vec++;
    if (seen != 1 || lat != MS || got !== e) begin
      n_err++;
      $display("FAIL midreset_after: got %0d beats lat %0d %h expected 1 beat lat %0d %h",
               seen, lat, got, MS, e);
    end
  endtask

  task automatic test_param_variants();
    do_reset();
    exp_q.delete(); s1_q.delete(); w_q.delete();
    for (int c = 0; c < 120; c++) begin
      logic [31:0] av, bv;
      logic        ci, sb, v;
      int          cur;
      cur = cyc;
      av = rnd32(); bv = rnd32();
      ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      v  = (c < 100) && ($urandom_range(0, 3) != 0);
      drive(v, av, bv, ci, sb, 1'b1);
      if (v) begin
        n_vec++;
        if ({m_rdy, s_rdy, w_rdy} !== 3'b111) begin
          n_err++;
          $display("FAIL var_ready[%0d]: got %b expected 111", c, {m_rdy, s_rdy, w_rdy});
        end
      end
      if (s_vld) begin
        logic [EW-1:0] e;
        n_vec++;
        e = (s1_q.size() != 0) ? s1_q.pop_front() : '1;
        if (s_res !== e[34:0] || 16'(cur) - e[50:35] != 16'd1) begin
          n_err++;
          $display("FAIL s1_result[%0d]: got %h expected %h lat 1", c, s_res, e[34:0]);
        end
      end
      if (w_vld) begin
        logic [EW-1:0] e;
        n_vec++;
        e = (w_q.size() != 0) ? w_q.pop_front() : '1;
        if (w_res !== e[34:0] || 16'(cur) - e[50:35] != 16'd2) begin
          n_err++;
          $display("FAIL w16_result[%0d]: got %h expected %h lat 2", c, w_res, e[34:0]);
        end
      end
      if (m_vld) begin
        logic [EW-1:0] e;
        n_vec++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (m_res !== e[34:0] || 16'(cur) - e[50:35] != 16'd2) begin
          n_err++;
          $display("FAIL main_result[%0d]: got %h expected %h lat 2", c, m_res, e[34:0]);
        end
      end
      if (v && m_rdy) exp_q.push_back({16'(cur), model(av, bv, ci, sb, 32)});
      if (v && s_rdy) s1_q.push_back({16'(cur), model(av, bv, ci, sb, 32)});
      if (v && w_rdy) w_q.push_back({16'(cur), model(av, bv, ci, sb, 16)});
    end
    n_vec++;
    if (exp_q.size() != 0 || s1_q.size() != 0 || w_q.size() != 0) begin
      n_err++;
      $display("FAIL var_drain: got %0d/%0d/%0d left expected 0/0/0",
               exp_q.size(), s1_q.size(), w_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_param_variants();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides.
- Successor to the team's fixed 8-bit structural lookahead adder, generalised in width, lookahead group size and pipeline depth.
- Adds subtract mode, signed-overflow and zero flags, and backpressure.
- Sits between operand-producing logic and the ALU result bus, and accepts one operation per cycle at full throughput.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group; group P/G are computed in parallel and the group carry chain is lookahead.
- STAGES, 2, pipeline register stages = latency in cycles; legal range 1 .. WIDTH/GROUP.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat is valid.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; set to 1 for plain subtraction.
- sub  input  1  0 = add, 1 = subtract (B inverted).
- out_valid  output  1  result beat is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Arithmetic:
  - B' = b XOR {WIDTH{sub}}.
  - {cout, sum} = a + B' + cin, computed modulo 2^(WIDTH+1).
  - cin is used as-is in both modes, so chained multi-word subtract works with cin as the inverted borrow.
- Flags:
  - ovf = (a[MSB] == B'[MSB]) AND (sum[MSB] != a[MSB]).
  - zero = (sum == 0), regardless of cout.
- Per bit: p = a^B', g = a&B'.
- Per group: GP = AND of p, GG = lookahead-generated.
- Group carries form a lookahead chain. Group c0 = cin.
- Within a group, sum_i = p_i ^ c_i.
- The WIDTH/GROUP groups are split into STAGES contiguous slices, earliest slice containing the LSB group.
  - Slice sizes: ceil/floor, any split allowed.
  - Each pipeline register holds: the carry leaving its slice, the finished low sum bits, the remaining unconsumed operand bits, and a valid bit.
  - Functional result must be independent of the split.
- Handshake:
  - Transfer on the input side when in_valid && in_ready. Transfer on the output side when out_valid && out_ready.
  - Each stage k holds valid_k. Stage k advances when it is empty or stage k+1 advances; the last stage advances when out_ready is high or it is empty.
  - in_ready = stage 0 advances. It is combinational from out_ready through the ready chain, with no combinational path from in_valid.
  - out_valid = valid of the last stage. sum/cout/ovf/zero are registered outputs of the last stage and stay stable while out_valid && !out_ready.
- Latency and throughput:
  - An accepted beat appears at out_valid exactly STAGES cycles later if there is no backpressure.
  - Throughput is 1 beat/cycle with out_ready held high.
  - Bubbles collapse: an empty stage always accepts from the stage before it.
- Backpressure: when out_ready is low with a full pipeline, every stage holds and in_ready = 0. No beat is lost or duplicated.
- Simultaneous events: with the last stage full and out_ready = 1, a new input is accepted in the same cycle. Output order equals input order.
- Reset:
  - Asserting rst clears all valid bits and all pipeline data, so sum/cout/ovf/zero = 0 and out_valid = 0. in_ready becomes 1 after reset.
  - In-flight beats are discarded on reset mid-operation.
  - The first accept is possible on the first clock edge after rst deasserts.
- Data registers of empty stages may hold stale values but must not raise out_valid.

Test Plan:
- WIDTH=32, GROUP=4, STAGES=2, out_ready=1.
  - a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 2 cycles: sum=0x00000000, cout=1, zero=1, ovf=0 (full carry ripple across every group).
  - a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 -> sum=0x80000000, ovf=1, cout=0, zero=0.
  - a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - Back-to-back stream of 100 random beats, in_valid always 1 -> one result per cycle after 2 cycles of latency, matching a reference model in order.
- Backpressure: stream 6 beats while holding out_ready=0 for cycles 3-8 -> in_ready drops to 0 once the pipeline is full, outputs stay stable, and all 6 results arrive in order with none lost.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and sum=0 immediately. Those beats never appear. The next beat after reset completes with latency 2.
- Repeat the random stream for STAGES=1 and for WIDTH=16, GROUP=8, STAGES=2 -> results match the model, with latency = STAGES.
